// File: rtl/tcb_lite_pkg.sv
// tcb_lite_pkg
// Shared constants for the TCB-lite memory model:
//   - response status encoding (STS_OK / STS_ERR)
//   - legal range of the response delay parameter and a helper to test it
package tcb_lite_pkg;

  localparam logic STS_OK  = 1'b0;
  localparam logic STS_ERR = 1'b1;

  localparam int DLY_MIN = 0;
  localparam int DLY_MAX = 4;

  function automatic logic dly_legal(input int dly);
    return (dly >= DLY_MIN) && (dly <= DLY_MAX);
  endfunction

endpackage

// File: rtl/tcb_lite_dly_pipe.sv
// tcb_lite_dly_pipe
// DLY-stage register pipe carrying a valid bit and a W-bit payload.
// DLY = 0 is a pure pass-through (no registers).
// Ports:
//   clk_i    clock, rising edge
//   clr_i    synchronous active-high clear of all valid bits and payloads
//   vld_i    input valid
//   dat_i    input payload
//   vld_o    valid after DLY cycles
//   dat_o    payload after DLY cycles
module tcb_lite_dly_pipe #(
  parameter int DLY = 1,
  parameter int W   = 33
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  if (DLY == 0) begin : g_pass
    assign vld_o = vld_i;
    assign dat_o = dat_i;
    // Clock and clear have no job when there are no stages.
    logic unused_clk_clr;
    assign unused_clk_clr = clk_i ^ clr_i;
  end else begin : g_pipe
    logic [DLY-1:0] vld_q;
    logic [W-1:0]   dat_q [DLY];

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        vld_q <= '0;
        for (int i = 0; i < DLY; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        dat_q[0] <= dat_i;
        for (int i = 1; i < DLY; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[DLY-1];
    assign dat_o = dat_q[DLY-1];
  end

endmodule

// File: rtl/tcb_lite_vip_memory.sv
// tcb_lite_vip_memory
// Byte-addressed memory model for a TCB-lite manager. Fixed-latency
// responses (DLY cycles), optional periodic backpressure on rdy.
//
// Handshake: a transfer (trn) happens on a rising edge where vld & rdy are
// both 1. rdy depends only on reset and a free-running phase counter, never
// on vld or request fields. Request fields are don't-care when trn = 0.
// Every trn produces exactly one response DLY cycles later, in order.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   vld      request valid
//   rdy      request ready
//   req_wen  1 = write, 0 = read
//   req_adr  byte address (low log2(DW/8) bits ignored)
//   req_ben  byte enables (writes)
//   req_wdt  write data
//   rsp_rdt  read data (0 for writes and address errors)
//   rsp_sts  1 = address error
module tcb_lite_vip_memory
  import tcb_lite_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int DLY     = 1,
  parameter int BPR_PER = 0,
  parameter int BPR_LEN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld,
  output logic            rdy,
  input  logic            req_wen,
  input  logic [31:0]     req_adr,
  input  logic [DW/8-1:0] req_ben,
  input  logic [DW-1:0]   req_wdt,
  output logic [DW-1:0]   rsp_rdt,
  output logic            rsp_sts
);

  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = AW - BW;

  if (!dly_legal(DLY)) begin : g_bad_dly
    $error("tcb_lite_vip_memory: DLY outside legal range 0..4");
  end
  if ((BPR_PER > 0) && (BPR_LEN >= BPR_PER)) begin : g_bad_bpr
    $error("tcb_lite_vip_memory: BPR_LEN must be below BPR_PER");
  end
  if ((AW >= 32) || (BW < 1)) begin : g_bad_geom
    $error("tcb_lite_vip_memory: need AW < 32 and DW >= 16");
  end

  // ---------------------------------------------------------------- ready
  if (BPR_PER == 0) begin : g_no_bpr
    assign rdy = ~rst;
  end else begin : g_bpr
    localparam int PW = (BPR_PER > 1) ? $clog2(BPR_PER) : 1;
    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PW'(BPR_PER - 1)) phase_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
    end

    // Low for the first BPR_LEN cycles of every period.
    assign rdy = ~rst & (int'(phase_q) >= BPR_LEN);
  end

  // --------------------------------------------------------------- memory
  logic          trn;
  logic          adr_err;
  logic [IW-1:0] idx;
  logic [DW-1:0] mem_q [2**IW];
  logic          unused_adr_lo;

  assign trn           = vld & rdy;
  assign adr_err       = |req_adr[31:AW];
  assign idx           = req_adr[AW-1:BW];
  assign unused_adr_lo = ^req_adr[BW-1:0];

  // No reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (trn && req_wen && !adr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_ben[i]) mem_q[idx][8*i +: 8] <= req_wdt[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------------- response
  // The read is taken combinationally from mem_q in the trn cycle, so a
  // write landing on the same edge is not yet visible.
  logic [DW:0] rsp_d;
  logic        pipe_vld;
  logic [DW:0] pipe_dat;
  logic [DW-1:0] rdt_hold_q;

  assign rsp_d = {(adr_err ? STS_ERR : STS_OK),
                  ((req_wen || adr_err) ? '0 : mem_q[idx])};

  tcb_lite_dly_pipe #(
    .DLY (DLY),
    .W   (DW + 1)
  ) u_pipe (
    .clk_i (clk),
    .clr_i (rst),
    .vld_i (trn),
    .dat_i (rsp_d),
    .vld_o (pipe_vld),
    .dat_o (pipe_dat)
  );

  // Between responses rsp_rdt keeps the last delivered data; rsp_sts only
  // reports an error while a response is actually delivered.
  always_ff @(posedge clk) begin
    if (rst)           rdt_hold_q <= '0;
    else if (pipe_vld) rdt_hold_q <= pipe_dat[DW-1:0];
  end

  assign rsp_rdt = pipe_vld ? pipe_dat[DW-1:0] : rdt_hold_q;
  assign rsp_sts = pipe_vld ? pipe_dat[DW]     : STS_OK;

endmodule

// File: doc/tcb_lite_vip_memory.md
TCB_LITE_VIP_MEMORY -- requirements
Module: tcb_lite_vip_memory

Interface
REQ-001 Parameter AW, default 10, byte address width; memory size 2**AW bytes.
REQ-002 Parameter DW, default 32, data width; DW/8 byte lanes.
REQ-003 Parameter DLY, default 1, response delay in cycles; legal range 0..4.
REQ-004 Parameter BPR_PER, default 0, backpressure period in cycles; 0 disables backpressure.
REQ-005 Parameter BPR_LEN, default 0, cycles per period with rdy low; legal only if BPR_LEN < BPR_PER.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 vld  input  1  request valid from manager.
REQ-009 rdy  output  1  request ready; transfer trn = vld & rdy.
REQ-010 req_wen  input  1  1 = write, 0 = read.
REQ-011 req_adr  input  32  byte address; word aligned, low log2(DW/8) bits ignored.
REQ-012 req_ben  input  DW/8  byte enables, write only.
REQ-013 req_wdt  input  DW  write data.
REQ-014 rsp_rdt  output  DW  read data, valid DLY cycles after trn.
REQ-015 rsp_sts  output  1  response status; 1 = address error.

Function
REQ-016 rdy: with BPR_PER=0, constantly 1 outside reset.
REQ-017 With BPR_PER>0, free-running phase counter 0..BPR_PER-1, wraps to 0; rdy=0 when phase < BPR_LEN, else 1.
REQ-018 Phase counter advances every cycle regardless of vld; rdy is not a function of vld.
REQ-019 Transfer: rdy must not depend combinationally on any request signal.
REQ-020 Write trn, in-range address: each byte lane with req_ben set written at trn edge; other lanes unchanged.
REQ-021 Read trn: rsp_rdt returns the memory word as it was before any write on the same edge.
REQ-022 Write response: rsp_rdt = 0; rsp_sts = 0.
REQ-023 Address error: req_adr >= 2**AW -> no memory write, rsp_rdt = 0, rsp_sts = 1.
REQ-024 Latency: response for trn at edge N presented on rsp_* during cycle N+DLY (between edges N+DLY-1 and N+DLY, sampled at edge N+DLY); DLY=0 means combinational read path in the trn cycle.
REQ-025 Back-to-back: one trn per cycle sustained; response order equals request order; pipeline depth DLY, no stalls.
REQ-026 No-transfer cycles: rsp_rdt and rsp_sts hold last presented value (not X), status 0 unless a response is delivered.
REQ-027 Request signals ignored when trn=0; no memory update.

Reset
REQ-028 During rst: rdy=0, phase counter=0, response pipeline valid bits and data cleared, rsp_rdt=0, rsp_sts=0.
REQ-029 First cycle after rst deassertion: phase=0, so rdy=0 if BPR_LEN>0, else 1.
REQ-030 Transfers in flight when rst asserts are discarded; no response appears after reset.
REQ-031 Memory array contents are not reset; preserved across rst.

Structure
REQ-032 tcb_lite_pkg holds rsp_sts encoding constants (OK=0, ERR=1) and the DLY legal-range constant.
REQ-033 Sub-module tcb_lite_dly_pipe: parameterised DLY-stage register pipe with valid bit, synchronous active-high clear; DLY=0 is pass-through.
REQ-034 Elaboration-time assertion fails for DLY>4 or BPR_LEN >= BPR_PER when BPR_PER>0.

Verification
REQ-035 DLY=1, BPR_PER=0: write adr 0x10, ben 0xF, wdt 0xDEADBEEF; read 0x10 next cycle -> rsp_rdt 0xDEADBEEF one cycle after read trn, rsp_sts 0.
REQ-036 Partial write: ben 0x2, wdt 0x0000AA00 over 0xDEADBEEF -> read returns 0xDEADAAEF.
REQ-037 Same-edge read/write ordering: read 0x20 then write 0x20 0x12345678 back-to-back, DLY=2 -> first rsp_rdt old value, later read returns 0x12345678; responses exactly 2 cycles after each trn.
REQ-038 Address error: read 0x400 with AW=10 -> rsp_sts 1, rsp_rdt 0; following write to 0x400 leaves memory unchanged.
REQ-039 Backpressure BPR_PER=4, BPR_LEN=1, vld held high 12 cycles -> rdy pattern 0,1,1,1 repeating, 9 transfers, responses in order.
REQ-040 Reset mid-operation: rst asserted one cycle after read trn with DLY=3 -> no response delivered, rsp_rdt 0, memory contents intact after rst.
